// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared constants for the MIPS register file and the WB destination mux:
// default widths, register count and the architecturally fixed register
// numbers (r0 = zero, r31 = JAL link register).
// -----------------------------------------------------------------------------
package register_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bus bundle between the pipeline (master) and the register file (slave).
//   rd_addr_a/rd_data_a : read port A (rs), combinational
//   rd_addr_b/rd_data_b : read port B (rt), combinational
//   wr_en/wr_addr/wr_data : WB-stage write port
//   dbg_addr/dbg_data   : debug inspection port, never bypassed
//   wr_count            : saturating count of committed writes
// -----------------------------------------------------------------------------
interface register_file_if #(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
);

    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       wr_count;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data, wr_count
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data, wr_count
    );

endinterface

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port: selects the addressed register, forces r0 to
// zero and, when REGFILE_WR_BYPASS_EN is defined, forwards the in-flight WB
// write data on an address match.
//   regs    : flattened register array (entry i = regs[i])
//   rd_addr : register number to read
//   wr_en/wr_addr/wr_data : current write port, used only for forwarding
//   rd_data : read result
// Optional feature macro: REGFILE_WR_BYPASS_EN
// -----------------------------------------------------------------------------
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [DATA_W-1:0]                  rd_data
);

`ifdef REGFILE_WR_BYPASS_EN
    // Forwarding resolves the WB->ID hazard in the same cycle; r0 is excluded
    // so a discarded write to r0 can never leak onto a read port.
    always_comb begin
        rd_data = regs[rd_addr];
        if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`else
    // Stored contents only; the hazard unit is responsible for same-cycle
    // WB->ID conflicts in this build.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32-entry MIPS general-purpose register file: two combinational read ports
// (ID stage), one synchronous write port (WB stage), a debug read port and a
// saturating committed-write counter. r0 is hardwired to zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all registers and wr_count
//   bus   : register_file_if slave modport (read/write/debug ports, wr_count)
// Optional feature macro: REGFILE_WR_BYPASS_EN (write-to-read forwarding on
// ports A and B; the debug port is never bypassed).
// -----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [15:0]                   wr_count_q, wr_count_d;
    logic                          wr_commit;

    // A write to r0 is discarded entirely, including the counter update.
    assign wr_commit = bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO));

    // Next-state for the array and the counter; the counter sticks at
    // all-ones instead of wrapping.
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    // Reset has priority over any write presented on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .regs    (regs_q),
        .rd_addr (bus.rd_addr_a),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rd_data_a)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .regs    (regs_q),
        .rd_addr (bus.rd_addr_b),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rd_data_b)
    );

    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs_q[bus.dbg_addr];
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed bench for register_file. Inputs change on the falling edge and
// outputs are sampled shortly after, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive every master-side input at a falling edge, then let it settle.
    task automatic applyStimulus(input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic [4:0] da);
        @(negedge clk);
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        bus.dbg_addr  = da;
        #2;
    endtask

    // One committed write, with the write port idled after the edge.
    task automatic doWrite(input logic [4:0] wa, input logic [31:0] wd);
        applyStimulus(1'b1, wa, wd, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.dbg_addr = '0;

        // Reset state: unwritten registers read zero, counter zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd19, 5'd31);
        checkOutput("reset_rd_a", bus.rd_data_a, 32'h0);
        checkOutput("reset_rd_b", bus.rd_data_b, 32'h0);
        checkOutput("reset_dbg", bus.dbg_data, 32'h0);
        checkOutput("reset_count", {16'h0, bus.wr_count}, 32'h0);

        // Write a few registers, then pulse reset between edges.
        doWrite(5'd3, 32'h0000_0011);
        doWrite(5'd7, 32'h0000_0022);
        doWrite(5'd12, 32'h0000_0033);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 5'd12);
        checkOutput("pre_rst_rd_a", bus.rd_data_a, 32'h0000_0011);
        checkOutput("pre_rst_rd_b", bus.rd_data_b, 32'h0000_0022);
        checkOutput("pre_rst_dbg", bus.dbg_data, 32'h0000_0033);
        checkOutput("pre_rst_count", {16'h0, bus.wr_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd_a", bus.rd_data_a, 32'h0);
        checkOutput("async_rst_rd_b", bus.rd_data_b, 32'h0);
        checkOutput("async_rst_dbg", bus.dbg_data, 32'h0);
        checkOutput("async_rst_count", {16'h0, bus.wr_count}, 32'h0);
        rst_n = 1'b1;

        // Both ports read the same register.
        doWrite(5'd5, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        checkOutput("r5_rd_a", bus.rd_data_a, 32'hDEAD_BEEF);
        checkOutput("r5_rd_b", bus.rd_data_b, 32'hDEAD_BEEF);
        checkOutput("r5_count", {16'h0, bus.wr_count}, 32'd1);

        // Write to r0 is discarded and never forwarded.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_bypass_rd_a", bus.rd_data_a, 32'h0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_rd_a", bus.rd_data_a, 32'h0);
        checkOutput("r0_dbg", bus.dbg_data, 32'h0);
        checkOutput("r0_count", {16'h0, bus.wr_count}, 32'd1);

        // JAL link register.
        doWrite(5'd31, 32'h0000_0010);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd31);
        checkOutput("r31_dbg", bus.dbg_data, 32'h0000_0010);
        checkOutput("r31_count", {16'h0, bus.wr_count}, 32'd2);

        // Same-cycle WB->ID hazard on r8; port B reads r5 independently.
        doWrite(5'd8, 32'h0000_0001);
        applyStimulus(1'b1, 5'd8, 32'h0000_0002, 5'd8, 5'd5, 5'd8);
`ifdef REGFILE_WR_BYPASS_EN
        checkOutput("hazard_rd_a", bus.rd_data_a, 32'h0000_0002);
`else
        checkOutput("hazard_rd_a", bus.rd_data_a, 32'h0000_0001);
`endif
        checkOutput("hazard_rd_b", bus.rd_data_b, 32'hDEAD_BEEF);
        checkOutput("hazard_dbg", bus.dbg_data, 32'h0000_0001);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        #1;
        checkOutput("post_hazard_rd_a", bus.rd_data_a, 32'h0000_0002);
        checkOutput("post_hazard_dbg", bus.dbg_data, 32'h0000_0002);
        checkOutput("post_hazard_count", {16'h0, bus.wr_count}, 32'd4);

        // Saturation: 65537 further writes to r1, data = loop index.
        applyStimulus(1'b1, 5'd1, 32'h0, 5'd1, 5'd0, 5'd1);
        for (int i = 0; i < 65537; i++) begin
            bus.wr_data = 32'(i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        #2;
        checkOutput("sat_count", {16'h0, bus.wr_count}, 32'h0000_FFFF);
        checkOutput("sat_r1", bus.rd_data_a, 32'h0001_0000);
        doWrite(5'd1, 32'h1234_5678);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1);
        checkOutput("sat_hold_count", {16'h0, bus.wr_count}, 32'h0000_FFFF);
        checkOutput("sat_hold_r1", bus.dbg_data, 32'h1234_5678);

        // Reset asserted while a write is presented: reset wins.
        applyStimulus(1'b1, 5'd1, 32'h0000_ABCD, 5'd1, 5'd0, 5'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_wr_r1", bus.dbg_data, 32'h0);
        checkOutput("rst_wr_count", {16'h0, bus.wr_count}, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_rst_r1", bus.rd_data_a, 32'h0);
        checkOutput("after_rst_count", {16'h0, bus.wr_count}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
